// File: rtl/decode_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : decode_fetch_controller
// Description : Fetch sequencer for the decoder byte queue. Issues word
//               fetches, writes responses, forwards consume requests and
//               flushes on PC redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_fetch_controller #(
  parameter int QUEUE_LEN = 64,
  parameter int INP_LEN   = 4,
  parameter int ADDR_W    = 16,
  parameter int MAX_OUT   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 redirect,
  input  logic [ADDR_W-1:0]    redirect_addr,
  output logic                 mem_req,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [8*INP_LEN-1:0] mem_rdata,
  input  logic [7:0]           q_len,
  output logic                 q_we,
  output logic [8*INP_LEN-1:0] q_din,
  output logic                 q_se,
  output logic [7:0]           q_sa,
  output logic                 q_flush,
  input  logic                 cons_req,
  input  logic [7:0]           cons_amt,
  output logic                 cons_ack
);

  localparam logic [9:0]        c_inp_len = 10'(INP_LEN);
  localparam logic [9:0]        c_q_max   = 10'(QUEUE_LEN);
  localparam logic [1:0]        c_max_out = 2'(MAX_OUT);
  localparam logic [ADDR_W-1:0] c_pc_step = ADDR_W'(INP_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [1:0]        r_out;
  logic              r_req;
  logic              r_flush;

  logic       w_redir;
  logic       w_gnt;
  logic       w_resp;
  logic [1:0] w_out_inc;
  logic [1:0] w_out_nxt;
  logic [7:0] w_qlen_eff;
  logic [9:0] w_need;
  logic       w_space;
  logic       w_req_nxt;

  // Redirects outside IDLE flush the queue; in IDLE they only reload the PC.
  assign w_redir    = redirect && (r_state != S_IDLE);
  assign w_gnt      = r_req && mem_gnt;
  assign w_resp     = mem_rvalid && (r_out != 2'd0);
  assign w_out_inc  = r_out + {1'b0, w_gnt};
  assign w_out_nxt  = w_out_inc - {1'b0, w_resp};
  assign w_qlen_eff = r_flush ? 8'd0 : q_len;

  // Bytes already queued plus every word in flight, including the next one.
  assign w_need  = {2'b00, w_qlen_eff} + c_inp_len * ({8'd0, w_out_inc} + 10'd1);
  assign w_space = (w_need <= c_q_max) && (w_out_inc < c_max_out);

  assign w_req_nxt = (r_state == S_RUN) && en && !redirect &&
                     ((r_req && !mem_gnt) || w_space);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (en) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_redir)
          w_state_nxt = (w_out_nxt != 2'd0) ? S_DRAIN : S_RUN;
        else if (!en && (r_out == 2'd0) && !w_gnt)
          w_state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (w_out_nxt == 2'd0) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_out   <= 2'd0;
      r_req   <= 1'b0;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_req   <= w_req_nxt;
      r_flush <= w_redir;
      if (redirect)
        r_pc <= redirect_addr;
      else if (w_gnt)
        r_pc <= r_pc + c_pc_step;
    end
  end

  assign mem_req  = r_req;
  assign mem_addr = r_pc;
  assign q_flush  = r_flush;

  // A stale q_len during flush is treated as empty, so nothing is consumed.
  assign q_we     = rst && (r_state == S_RUN) && w_resp && !redirect;
  assign q_din    = mem_rdata;
  assign cons_ack = rst && (r_state == S_RUN) && cons_req && !redirect &&
                    (cons_amt != 8'd0) && (cons_amt <= w_qlen_eff);
  assign q_se     = cons_ack;
  assign q_sa     = cons_ack ? cons_amt : 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_decode_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_fetch_controller
// Description : Randomised bench with a memory/queue environment, a
//               transaction-level reference model and a write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_fetch_controller;

  localparam int QL = 64;

  logic        clk = 1'b0;
  logic        rst, en, redirect;
  logic [15:0] redirect_addr;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata, q_din;
  logic [7:0]  q_len, q_sa, cons_amt;
  logic        q_we, q_se, q_flush, cons_req, cons_ack;

  always #5 clk = ~clk;

  decode_fetch_controller #(
    .QUEUE_LEN(64), .INP_LEN(4), .ADDR_W(16), .MAX_OUT(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .redirect(redirect),
    .redirect_addr(redirect_addr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .q_len(q_len), .q_we(q_we), .q_din(q_din), .q_se(q_se), .q_sa(q_sa),
    .q_flush(q_flush), .cons_req(cons_req), .cons_amt(cons_amt),
    .cons_ack(cons_ack)
  );

  typedef struct {
    int          epoch;
    logic [31:0] data;
    int          due;
  } rsp_t;

  int          n_chk = 0;
  int          n_fail = 0;
  rsp_t        pend[$];
  logic [31:0] exp_q[$];
  int          cyc = 0;
  int          epoch = 0;
  logic [15:0] m_pc = 16'h0;
  bit          running = 1'b0;
  bit          flush_exp = 1'b0;
  int          qlen_m = 0;
  int          grants = 0;

  bit          k_rst = 1'b0, k_en = 1'b0, k_stray = 1'b0, k_fixed = 1'b1, k_fr = 1'b0;
  int          k_gnt = 100, k_rsp = 100, k_lat = 2, k_cons = 0, k_redir = 0, k_force = 0;
  logic [15:0] k_fr_addr = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // One clock of environment + model: drive at negedge, judge 1ns later.
  task automatic step();
    bit   draining, redir_eff, gnt_now, rsp_now, exp_ack;
    int   pend0, live;
    rsp_t r;
    @(negedge clk);
    rst = k_rst;
    en  = k_en;
    if (k_fr) begin
      redirect = 1'b1; redirect_addr = k_fr_addr; k_fr = 1'b0;
    end else begin
      redirect = k_en && running && ($urandom_range(99) < k_redir);
      redirect_addr = 16'($urandom);
    end
    mem_gnt    = ($urandom_range(99) < k_gnt);
    rsp_now    = (pend.size() > 0) && (pend[0].due <= cyc) && ($urandom_range(99) < k_rsp);
    mem_rvalid = rsp_now || k_stray;
    mem_rdata  = rsp_now ? pend[0].data : $urandom;
    q_len      = 8'(qlen_m);
    if (k_force != 0) begin
      cons_req = 1'b1; cons_amt = 8'(k_force); k_force = 0;
    end else begin
      cons_req = ($urandom_range(99) < k_cons);
      cons_amt = 8'($urandom_range(8));
    end
    #1;
    draining = 1'b0;
    foreach (pend[i]) if (pend[i].epoch != epoch) draining = 1'b1;
    redir_eff = redirect && running;
    pend0 = pend.size();

    chk("q_flush", q_flush, flush_exp);
    chk("mem_addr", mem_addr, m_pc);
    if (!running || draining || flush_exp) chk("mem_req_quiet", mem_req, 1'b0);
    exp_ack = k_rst && running && !draining && cons_req && !redirect && (cons_amt != 0) &&
              (int'(cons_amt) <= (flush_exp ? 0 : qlen_m));
    chk("cons_ack", cons_ack, exp_ack);
    chk("q_se", q_se, exp_ack);
    if (exp_ack) chk("q_sa", q_sa, cons_amt);

    gnt_now = mem_req && mem_gnt && k_rst;
    if (gnt_now) begin
      chk("outstanding_limit", pend0, (pend0 < 2) ? pend0 : 1);
      grants++;
      r.epoch = epoch;
      r.data  = $urandom;
      r.due   = cyc + (k_fixed ? k_lat : int'($urandom_range(k_lat, 1)));
      pend.push_back(r);
    end
    if (rsp_now && k_rst) begin
      if (pend[0].epoch == epoch && running && !draining && !redirect)
        exp_q.push_back(pend[0].data);
      void'(pend.pop_front());
    end

    // The queue itself: flush clears, otherwise write and shift combine.
    if (q_flush) qlen_m = 0;
    else qlen_m = qlen_m + (q_we ? 4 : 0) - (q_se ? int'(q_sa) : 0);

    if (!k_rst) begin
      running = 1'b0; m_pc = 16'h0; flush_exp = 1'b0; pend.delete(); epoch++;
    end else begin
      if (running && !draining && !en && pend0 == 0 && !gnt_now && !redir_eff) running = 1'b0;
      else if (!running && en) running = 1'b1;
      flush_exp = redir_eff;
      if (redirect) m_pc = redirect_addr;
      else if (gnt_now) m_pc = m_pc + 16'd4;
      if (redir_eff) epoch++;
    end
    live = 0;
    foreach (pend[i]) if (pend[i].epoch == epoch) live++;
    chk("no_overflow", (qlen_m >= 0 && qlen_m + 4 * live <= QL) ? 1 : 0, 1);
    cyc++;
  endtask

  // Scoreboard monitor: every queue write must match the oldest expected word.
  always @(negedge clk) begin
    #2;
    if (q_we === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL q_we_unexpected: cycle %0d got q_din 0x%0h expected no write", cyc, q_din);
      end else begin
        logic [31:0] d;
        d = exp_q.pop_front();
        if (q_din !== d) begin
          n_fail++;
          $display("FAIL q_din: cycle %0d got 0x%0h expected 0x%0h", cyc, q_din, d);
        end
      end
    end else if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL q_we_missing: cycle %0d got q_we=%b expected write of 0x%0h", cyc, q_we, exp_q[0]);
      exp_q.delete();
    end
  end

  initial begin
    rst = 1'b0; en = 1'b0; redirect = 1'b0; redirect_addr = '0; mem_gnt = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0; q_len = '0; cons_req = 1'b0; cons_amt = '0;
    @(posedge clk);

    // Reset: outputs gated even with stray responses and consume requests
    qlen_m = 12; k_rst = 1'b0; k_stray = 1'b1; k_cons = 100;
    repeat (3) step();

    // Fill from empty with an always-granting memory, latency 2, no consume
    qlen_m = 0; k_rst = 1'b1; k_stray = 1'b0; k_cons = 0; k_en = 1'b1;
    k_gnt = 100; k_rsp = 100; k_fixed = 1'b1; k_lat = 2; grants = 0;
    repeat (60) step();
    chk("fill_level", qlen_m, 64);
    chk("fill_grants", grants, 16);

    // Space rule at the boundary: 60 -> one fetch, 61 -> none, 58 -> one
    grants = 0; k_force = 4; step(); repeat (10) step();
    chk("grants_at_60", grants, 1);
    chk("level_after_60", qlen_m, 64);
    grants = 0; k_force = 3; step(); repeat (10) step();
    chk("grants_at_61", grants, 0);
    k_force = 3; step(); repeat (10) step();
    chk("grants_at_58", grants, 1);
    chk("level_after_58", qlen_m, 62);

    // Redirect with two words in flight: both dropped, fetch resumes at 0x0100
    qlen_m = 0; k_rsp = 0; repeat (6) step();
    chk("two_in_flight", pend.size(), 2);
    k_fr = 1'b1; k_fr_addr = 16'h0100; step();
    k_rsp = 100; grants = 0; repeat (12) step();
    chk("post_redirect_grants", (grants >= 2) ? 1 : 0, 1);

    // Randomised traffic with consumes, back-pressure and redirects
    k_cons = 40; k_gnt = 60; k_rsp = 70; k_fixed = 1'b0; k_lat = 4; k_redir = 3;
    repeat (3000) step();

    // Disable fetch: outstanding words still land, then the block idles
    k_redir = 0; k_en = 1'b0; k_cons = 30; k_rsp = 100;
    repeat (40) step();
    chk("drained", pend.size(), 0);

    // Reset while a request waits for its grant, then stray responses
    qlen_m = 0; k_cons = 0; k_en = 1'b1; k_gnt = 0;
    repeat (5) step();
    chk("req_waiting", mem_req, 1'b1);
    k_rst = 1'b0; step();
    k_rst = 1'b1; step();
    chk("req_after_reset", mem_req, 1'b0);
    chk("addr_after_reset", mem_addr, 16'h0);
    k_stray = 1'b1; repeat (3) step();
    k_stray = 1'b0; repeat (3) step();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
